// File: rtl/spi_frame_counter.sv
// spi_frame_counter: programmable bit/frame counter for the SPI datapath.
// Define SPI_FRAME_COUNT_EN to add the completed-frame counter output.
module spi_frame_counter #(
    parameter int WIDTH      = 4,
    parameter int DEFAULT_TC = 10
`ifdef SPI_FRAME_COUNT_EN
    ,
    parameter int FRAME_W    = 8
`endif
) (
    input  logic               clk,
    input  logic               counter_rst,
    input  logic               counter_en,
    input  logic               start,
    input  logic               abort,
    input  logic               auto_reload,
    input  logic               tc_load,
    input  logic [WIDTH-1:0]   tc_value,
`ifdef SPI_FRAME_COUNT_EN
    output logic [FRAME_W-1:0] frame_count,
`endif
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               tc_flag,
    output logic               done
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;

    localparam logic [WIDTH-1:0] TC_RST = WIDTH'(DEFAULT_TC);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] tc_q, tc_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             tc_flag_q, tc_flag_d;
    logic [WIDTH-1:0] count_inc;
    logic             load_ok;

    assign count_inc = count_q + WIDTH'(1);
    assign load_ok   = tc_load && (tc_value != '0) &&
                       ((state_q == ST_IDLE) || (state_q == ST_HOLD));

    // Next-state, count, mode and terminal-count update.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        tc_d    = load_ok ? tc_value : tc_q;

        if (abort) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (start) begin
            state_d = ST_RUN;
            count_d = '0;
            mode_d  = auto_reload;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (counter_en) begin
                        // Only auto-reload can sit at the terminal in RUN.
                        if (count_q == tc_q) begin
                            count_d = '0;
                        end else begin
                            count_d = count_inc;
                            if (count_inc == tc_q) begin
                                done_d = 1'b1;
                                if (!mode_q) begin
                                    state_d = ST_HOLD;
                                end
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    count_d = count_q;
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end

        busy_d    = (state_d == ST_RUN);
        tc_flag_d = (state_d != ST_IDLE) && (count_d == tc_d);
    end

    // Register all state and outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!counter_rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            tc_q      <= TC_RST;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            tc_flag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            tc_q      <= tc_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            tc_flag_q <= tc_flag_d;
        end
    end

    assign count   = count_q;
    assign busy    = busy_q;
    assign tc_flag = tc_flag_q;
    assign done    = done_q;

`ifdef SPI_FRAME_COUNT_EN
    logic [FRAME_W-1:0] frame_q, frame_d;

    // Completed-frame tally, advanced together with each done pulse.
    always_comb begin
        frame_d = frame_q;
        if (done_d) begin
            frame_d = frame_q + FRAME_W'(1);
        end
    end

    // Frame counter flop; only reset clears it.
    always_ff @(posedge clk) begin
        if (!counter_rst) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign frame_count = frame_q;
`endif

endmodule

// File: tb/tb_spi_frame_counter.sv
// tb_spi_frame_counter: directed self-checking bench for spi_frame_counter.
// Frame-count checks are active when SPI_FRAME_COUNT_EN is defined.
module tb_spi_frame_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       start;
    logic       abort;
    logic       ar;
    logic       tc_load;
    logic [3:0] tc_value;
    logic [3:0] count;
    logic       busy;
    logic       tc_flag;
    logic       done;
`ifdef SPI_FRAME_COUNT_EN
    logic [1:0] frame_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int n_done;

    always #5 clk = ~clk;

    spi_frame_counter #(
        .WIDTH(4),
        .DEFAULT_TC(10)
`ifdef SPI_FRAME_COUNT_EN
        ,
        .FRAME_W(2)
`endif
    ) dut (
`ifdef SPI_FRAME_COUNT_EN
        .frame_count(frame_count),
`endif
        .clk(clk),
        .counter_rst(rst_n),
        .counter_en(en),
        .start(start),
        .abort(abort),
        .auto_reload(ar),
        .tc_load(tc_load),
        .tc_value(tc_value),
        .count(count),
        .busy(busy),
        .tc_flag(tc_flag),
        .done(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; start = 1'b1; abort = 1'b0;
        ar = 1'b0; tc_load = 1'b0; tc_value = 4'd0;

        // Reset with start and enable held
        tick();
        tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tcf", 32'(tc_flag), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
`ifdef SPI_FRAME_COUNT_EN
        chk("rst_frame", 32'(frame_count), 32'd0);
`endif
        rst_n = 1'b1; start = 1'b0;
        tick();
        tick();
        chk("idle_count", 32'(count), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // One-shot frame, terminal 10
        en = 1'b0; start = 1'b1; ar = 1'b0;
        tick();
        start = 1'b0;
        chk("os_start_cnt", 32'(count), 32'd0);
        chk("os_start_busy", 32'(busy), 32'd1);
        en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("os_count", 32'(count), 32'(i));
            chk("os_done", 32'(done), 32'(i == 10));
            chk("os_tcf", 32'(tc_flag), 32'(i == 10));
            chk("os_busy", 32'(busy), 32'(i != 10));
        end
        tick();
        chk("os_hold_cnt", 32'(count), 32'd10);
        chk("os_hold_done", 32'(done), 32'd0);
        chk("os_hold_tcf", 32'(tc_flag), 32'd1);
        chk("os_hold_busy", 32'(busy), 32'd0);
`ifdef SPI_FRAME_COUNT_EN
        chk("os_frame", 32'(frame_count), 32'd1);
`endif
        en = 1'b0;

        // Auto-reload with terminal 3
        do_reset();
        tc_load = 1'b1; tc_value = 4'd3;
        tick();
        tc_load = 1'b0;
        start = 1'b1; ar = 1'b1;
        tick();
        start = 1'b0; ar = 1'b0; en = 1'b1;
        n_done = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (done === 1'b1) n_done++;
            chk("ar_count", 32'(count), 32'(i % 4));
            chk("ar_done", 32'(done), 32'((i % 4) == 3));
            chk("ar_tcf", 32'(tc_flag), 32'((i % 4) == 3));
            chk("ar_busy", 32'(busy), 32'd1);
        end
        chk("ar_ndone", 32'(n_done), 32'd3);
`ifdef SPI_FRAME_COUNT_EN
        chk("ar_frame", 32'(frame_count), 32'd3);
`endif
        en = 1'b0;

        // Abort at 5, start+abort together, restart at 7
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0; en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("ab_pre", 32'(count), 32'd5);
        en = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_count", 32'(count), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        start = 1'b1; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'd0);
        chk("sa_count", 32'(count), 32'd0);
        tick();
        start = 1'b0; en = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("rs_pre", 32'(count), 32'd7);
        start = 1'b1;
        tick();
        start = 1'b0; en = 1'b0;
        chk("rs_count", 32'(count), 32'd0);
        chk("rs_done", 32'(done), 32'd0);
        chk("rs_busy", 32'(busy), 32'd1);

        // Load gating
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0; en = 1'b1; tc_load = 1'b1; tc_value = 4'd6;
        tick();
        tc_load = 1'b0;
        for (int i = 2; i <= 10; i++) begin
            tick();
            chk("lg_done", 32'(done), 32'(i == 10));
        end
        chk("lg_busy", 32'(busy), 32'd0);
        en = 1'b0; tc_load = 1'b1; tc_value = 4'd0;
        tick();
        chk("lg_zero_tcf", 32'(tc_flag), 32'd1);
        tc_value = 4'd15;
        tick();
        tc_load = 1'b0;
        chk("lg_15_tcf", 32'(tc_flag), 32'd0);
        chk("lg_15_cnt", 32'(count), 32'd10);
        start = 1'b1;
        tick();
        start = 1'b0; en = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("lg15_count", 32'(count), 32'(i));
            chk("lg15_done", 32'(done), 32'(i == 15));
        end
        en = 1'b0;

`ifdef SPI_FRAME_COUNT_EN
        // Frame counter wrap with 2-bit width
        do_reset();
        tc_load = 1'b1; tc_value = 4'd1;
        tick();
        tc_load = 1'b0;
        for (int f = 1; f <= 5; f++) begin
            start = 1'b1;
            tick();
            start = 1'b0; en = 1'b1;
            tick();
            en = 1'b0;
            tick();
            chk("fc_wrap", 32'(frame_count), 32'(f % 4));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_frame_counter.md
# spi_frame_counter

Parametrised, FSM-controlled bit/frame counter for the SPI datapath; successor to the fixed 4-bit, count-to-ten counter. Counts qualified `counter_en` pulses (one per shifted bit) from 0 up to a run-time programmable terminal count. Supports one-shot and auto-reload modes with start/abort control, a terminal-count level flag and a one-cycle done pulse. Sits between the SPI clock-edge detector and the shift-register/transaction controller.

## Interface
- `WIDTH`, 4: width of `count` and terminal-count register.
- `DEFAULT_TC`, 10: terminal count after reset; must be 1..2^WIDTH-1.
- `FRAME_W`, 8: width of `frame_count` (only with the macro).

- `clk` in 1: clock; all logic is on the rising edge.
- `counter_rst` in 1: synchronous, active-low reset.
- `counter_en` in 1: count-advance qualifier, one pulse per bit.
- `start` in 1: begin or restart a frame.
- `abort` in 1: terminate the frame, return to IDLE.
- `auto_reload` in 1: mode select, sampled only when `start` is accepted.
- `tc_load` in 1: load `tc_value` into the terminal-count register.
- `tc_value` in WIDTH: new terminal count.
- `count` out WIDTH: current count.
- `busy` out 1: high in RUN.
- `tc_flag` out 1: high while not IDLE and `count` == tc_reg.
- `done` out 1: one-cycle pulse at frame completion.
- `frame_count` out FRAME_W: completed frames; present only with the macro.

## Operation
- Reset values: `count`=0, `busy`=0, `tc_flag`=0, `done`=0, `frame_count`=0, state=IDLE, tc_reg=DEFAULT_TC, mode=one-shot.
- Reset mid-frame forces all reset values at the next edge. No `done` is produced.
- **IDLE**: `count` holds 0 and `counter_en` is ignored.
  - `start` → RUN with `count`=0; `auto_reload` is latched into mode.
- **RUN**: `counter_en` increments `count` by 1.
  - The increment that makes `count` equal tc_reg also sets `done` for the next cycle.
  - One-shot mode: the same edge moves the FSM to HOLD.
  - Auto-reload mode: the FSM stays in RUN. The next `counter_en` at `count`==tc_reg wraps `count` to 0. Period is tc_reg+1 enables and `done` fires once per period.
- **HOLD**: `count` stays at tc_reg, `tc_flag`=1, `busy`=0, `counter_en` is ignored.
  - `start` → RUN with `count`=0.
- `start` in RUN or HOLD restarts the frame: `count`=0, mode re-latched, no `done`.
- `abort` in any state → IDLE with `count`=0, no `done`.
- Priority: reset > `abort` > `start` > `counter_en`.
- `tc_load` is accepted only in IDLE or HOLD, and only when `tc_value` is nonzero. Otherwise it is ignored and tc_reg is unchanged.
  - `tc_load` in HOLD updates tc_reg, so `tc_flag` re-evaluates against the new value.
- Arithmetic is unsigned modulo 2^WIDTH. Because tc_reg ≤ 2^WIDTH-1, `count` never overflows.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- `count` changes on the edge where `counter_en`=1 is sampled.
- `busy` rises the cycle after `start` is sampled. It falls the cycle after the terminal increment in one-shot mode, or after `abort`.
- `done` is high exactly one cycle, coincident with the first cycle `count`==tc_reg.
- `tc_flag` is high for every cycle `count`==tc_reg outside IDLE. In auto-reload it drops the cycle after the wrap.
- `counter_en` on consecutive cycles is legal. Back-to-back increments are supported at full clock rate.

## Configuration
- `SPI_FRAME_COUNT_EN` defined:
  - `frame_count` exists and increments by 1 on every `done`.
  - It wraps from 2^FRAME_W-1 to 0.
  - It is cleared only by reset; `start` and `abort` do not affect it.
- Undefined: the `frame_count` port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=4, DEFAULT_TC=10 and a 10 ns clock.

- **Reset:** assert `counter_rst`=0 for 2 cycles, with `start`=1 and `counter_en`=1 held → `count`=0, `busy`=0, `tc_flag`=0, `done`=0, `frame_count`=0; after release with no `start`, `count` stays 0 despite `counter_en`=1.
- **One-shot:** `start` (auto_reload=0), then 10 continuous `counter_en` pulses → `count` steps 1..10; `done` and `tc_flag` both rise the cycle `count`=10; `done` is gone one cycle later; `busy`=0; `count` holds 10 under further enables; `frame_count`=1.
- **Auto-reload:** `tc_load` with `tc_value`=3 in IDLE, `start` (auto_reload=1), 12 enables → `count` sequence 1,2,3,0,1,2,3,0,1,2,3,0; `done` fires 3 times; `busy` stays 1; `frame_count`=3.
- **Abort and restart:** `abort` at `count`=5 → IDLE with `count`=0 and no `done`; `start`+`abort` in the same cycle → IDLE; `start` at `count`=7 in RUN → `count`=0 with no `done`.
- **Load gating:** `tc_load` with `tc_value`=6 in RUN is ignored (terminal stays 10); `tc_load` with `tc_value`=0 is ignored; `tc_load` with `tc_value`=15 in HOLD makes `tc_flag` 0; after `start` and 15 enables, `done` fires at `count`=15.
- **Frame-count wrap** (macro on, FRAME_W=2): 5 one-shot frames → `frame_count` reads 1,2,3,0,1.
